// File: rtl/load_scoreboard_pkg.sv
// Shared constants and helpers for the load scoreboard.
// Register index width and outstanding-producer counter width.
package load_scoreboard_pkg;

  localparam int NREG = 32;
  localparam int RW   = 5;
  localparam int CNTW = 6;

  typedef logic [RW-1:0] reg_idx_t;

  function automatic logic [CNTW-1:0] popcnt(
    input logic [NREG-1:0] v
  );
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + CNTW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/load_scoreboard_if.sv
// Decode-slot query, writeback release and status bundle.
// The pipeline side is master; the scoreboard is slave.
interface load_scoreboard_if;
  import load_scoreboard_pkg::*;

  logic            id_valid_1;
  logic            id_valid_2;
  reg_idx_t        id_rs1_1;
  reg_idx_t        id_rs2_1;
  reg_idx_t        id_rs1_2;
  reg_idx_t        id_rs2_2;
  logic            id_is_s_type_1;
  logic            id_is_s_type_2;
  reg_idx_t        id_rd_1;
  reg_idx_t        id_rd_2;
  logic            id_long_1;
  logic            id_long_2;
  logic            wb_en_1;
  logic            wb_en_2;
  reg_idx_t        wb_rd_1;
  reg_idx_t        wb_rd_2;
  logic            ID_stall_1;
  logic            ID_stall_2;
  logic [CNTW-1:0] busy_cnt;
  logic            sb_idle;

  modport master (
    output id_valid_1, id_valid_2,
    output id_rs1_1, id_rs2_1,
    output id_rs1_2, id_rs2_2,
    output id_is_s_type_1, id_is_s_type_2,
    output id_rd_1, id_rd_2,
    output id_long_1, id_long_2,
    output wb_en_1, wb_en_2,
    output wb_rd_1, wb_rd_2,
    input  ID_stall_1, ID_stall_2,
    input  busy_cnt, sb_idle
  );

  modport slave (
    input  id_valid_1, id_valid_2,
    input  id_rs1_1, id_rs2_1,
    input  id_rs1_2, id_rs2_2,
    input  id_is_s_type_1, id_is_s_type_2,
    input  id_rd_1, id_rd_2,
    input  id_long_1, id_long_2,
    input  wb_en_1, wb_en_2,
    input  wb_rd_1, wb_rd_2,
    output ID_stall_1, ID_stall_2,
    output busy_cnt, sb_idle
  );

endinterface

// File: rtl/load_scoreboard_hazard.sv
// Per-slot hazard: RAW on rs1/rs2 and WAW on rd against
// the release-bypassed busy vector. x0 never hazards.
module sb_hazard_check
  import load_scoreboard_pkg::*;
(
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  input  reg_idx_t        rd,
  input  logic            is_s_type,
  input  logic            lng,
  input  logic [NREG-1:0] eff_busy,
  output logic            hz
);

  logic h_rs1;
  logic h_rs2;
  logic h_rd;

  assign h_rs1 = (rs1 != '0) & eff_busy[rs1];
  // store data is forwarded later, so rs2 of a store is free
  assign h_rs2 = (rs2 != '0) & eff_busy[rs2] & ~is_s_type;
  assign h_rd  = (rd != '0) & eff_busy[rd] & lng;
  assign hz    = h_rs1 | h_rs2 | h_rd;

endmodule

// File: rtl/load_scoreboard.sv
// Register scoreboard for long-latency producers in the
// two-issue pipeline: marks at issue, releases at writeback.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int NREG = load_scoreboard_pkg::NREG,
  parameter int CNTW = load_scoreboard_pkg::CNTW
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  load_scoreboard_if.slave  sb
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic [NREG-1:0] rel;
  logic [NREG-1:0] set;
  logic [NREG-1:0] eff_busy;
  logic            hz_1;
  logic            hz_2;
  logic            stall_1;
  logic            stall_2;
  logic            pair_dep;
  logic            acc_1;
  logic            acc_2;

  always_comb begin
    rel = '0;
    if (sb.wb_en_1) rel[sb.wb_rd_1] = 1'b1;
    if (sb.wb_en_2) rel[sb.wb_rd_2] = 1'b1;
  end

  assign eff_busy = busy_q & ~rel;

  sb_hazard_check u_hz_1 (
    .rs1       (sb.id_rs1_1),
    .rs2       (sb.id_rs2_1),
    .rd        (sb.id_rd_1),
    .is_s_type (sb.id_is_s_type_1),
    .lng       (sb.id_long_1),
    .eff_busy  (eff_busy),
    .hz        (hz_1)
  );

  sb_hazard_check u_hz_2 (
    .rs1       (sb.id_rs1_2),
    .rs2       (sb.id_rs2_2),
    .rd        (sb.id_rd_2),
    .is_s_type (sb.id_is_s_type_2),
    .lng       (sb.id_long_2),
    .eff_busy  (eff_busy),
    .hz        (hz_2)
  );

  // slot 2 depends on a slot-1 producer issuing this cycle
  assign pair_dep = sb.id_valid_1 & sb.id_long_1
                  & (sb.id_rd_1 != '0)
                  & ((sb.id_rd_1 == sb.id_rs1_2)
                  | ((sb.id_rd_1 == sb.id_rs2_2)
                     & ~sb.id_is_s_type_2)
                  | (sb.id_long_2
                     & (sb.id_rd_2 == sb.id_rd_1)));

  assign stall_1 = sb.id_valid_1 & hz_1;
  assign stall_2 = sb.id_valid_2
                 & (hz_2 | stall_1 | pair_dep);

  assign acc_1 = sb.id_valid_1 & ~stall_1
               & sb.id_long_1 & (sb.id_rd_1 != '0);
  assign acc_2 = sb.id_valid_2 & ~stall_2
               & sb.id_long_2 & (sb.id_rd_2 != '0);

  always_comb begin
    set = '0;
    if (acc_1) set[sb.id_rd_1] = 1'b1;
    if (acc_2) set[sb.id_rd_2] = 1'b1;
  end

  always_comb begin
    busy_d    = (busy_q & ~rel) | set;
    busy_d[0] = 1'b0;
    cnt_d     = cnt_q + CNTW'(acc_1) + CNTW'(acc_2)
              - CNTW'(popcnt(busy_q & rel));
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb.ID_stall_1 = stall_1;
  assign sb.ID_stall_2 = stall_2;
  assign sb.busy_cnt   = cnt_q;
  assign sb.sb_idle    = (cnt_q == '0);

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard with a set-based
// ownership model checked every cycle plus literal checks.
module tb_load_scoreboard;
  import load_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   owned [NREG];

  load_scoreboard_if sb ();

  load_scoreboard dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (sb.wb_en_1 && sb.wb_rd_1 == r) return 1'b0;
    if (sb.wb_en_2 && sb.wb_rd_2 == r) return 1'b0;
    return owned[r];
  endfunction

  function automatic void model_stall(
    output bit s1,
    output bit s2
  );
    bit h1, h2, pd;
    h1 = blocked(sb.id_rs1_1)
      || (!sb.id_is_s_type_1 && blocked(sb.id_rs2_1))
      || (sb.id_long_1 && blocked(sb.id_rd_1));
    h2 = blocked(sb.id_rs1_2)
      || (!sb.id_is_s_type_2 && blocked(sb.id_rs2_2))
      || (sb.id_long_2 && blocked(sb.id_rd_2));
    pd = sb.id_valid_1 && sb.id_long_1 && sb.id_rd_1 != 0
      && (sb.id_rd_1 == sb.id_rs1_2
       || (sb.id_rd_1 == sb.id_rs2_2 && !sb.id_is_s_type_2)
       || (sb.id_long_2 && sb.id_rd_2 == sb.id_rd_1));
    s1 = sb.id_valid_1 && h1;
    s2 = sb.id_valid_2 && (h2 || s1 || pd);
  endfunction

  function automatic int model_cnt();
    int n = 0;
    foreach (owned[i]) if (owned[i]) n++;
    return n;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e1, e2;
    if (mon_en) begin
      model_stall(e1, e2);
      chk("mon_stall_1", 32'(sb.ID_stall_1), 32'(e1));
      chk("mon_stall_2", 32'(sb.ID_stall_2), 32'(e2));
      chk("mon_busy_cnt", 32'(sb.busy_cnt),
          32'(model_cnt()));
      chk("mon_sb_idle", 32'(sb.sb_idle),
          32'(model_cnt() == 0));
    end
  end

  task automatic tick();
    bit e1, e2;
    @(posedge clk);
    model_stall(e1, e2);
    if (rst || flush) begin
      foreach (owned[i]) owned[i] = 1'b0;
    end else begin
      if (sb.wb_en_1) owned[sb.wb_rd_1] = 1'b0;
      if (sb.wb_en_2) owned[sb.wb_rd_2] = 1'b0;
      if (sb.id_valid_1 && !e1 && sb.id_long_1
          && sb.id_rd_1 != 0)
        owned[sb.id_rd_1] = 1'b1;
      if (sb.id_valid_2 && !e2 && sb.id_long_2
          && sb.id_rd_2 != 0)
        owned[sb.id_rd_2] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    sb.id_valid_1 = 0;
    sb.id_valid_2 = 0;
    sb.id_rs1_1 = 0;
    sb.id_rs2_1 = 0;
    sb.id_rs1_2 = 0;
    sb.id_rs2_2 = 0;
    sb.id_is_s_type_1 = 0;
    sb.id_is_s_type_2 = 0;
    sb.id_rd_1 = 0;
    sb.id_rd_2 = 0;
    sb.id_long_1 = 0;
    sb.id_long_2 = 0;
    sb.wb_en_1 = 0;
    sb.wb_en_2 = 0;
    sb.wb_rd_1 = 0;
    sb.wb_rd_2 = 0;
  endtask

  task automatic issue1(input logic [4:0] rd);
    idle();
    sb.id_valid_1 = 1;
    sb.id_long_1 = 1;
    sb.id_rd_1 = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rst_busy_cnt", 32'(sb.busy_cnt), 0);
    chk("rst_sb_idle", 32'(sb.sb_idle), 1);
    chk("rst_stall_1", 32'(sb.ID_stall_1), 0);
    chk("rst_stall_2", 32'(sb.ID_stall_2), 0);

    // long op to x5, then RAW read, then bypassed release
    issue1(5'd5);
    sb.id_rs1_1 = 5'd1;
    sb.id_rs2_1 = 5'd2;
    #1 chk("t1_issue_stall", 32'(sb.ID_stall_1), 0);
    tick();
    idle();
    sb.id_valid_1 = 1;
    sb.id_rs1_1 = 5'd5;
    sb.id_rd_1 = 5'd3;
    #1;
    chk("t1_raw_stall", 32'(sb.ID_stall_1), 1);
    chk("t1_cnt1", 32'(sb.busy_cnt), 1);
    tick();
    tick();
    sb.wb_en_1 = 1;
    sb.wb_rd_1 = 5'd5;
    #1 chk("t1_bypass", 32'(sb.ID_stall_1), 0);
    tick();
    idle();
    #1 chk("t1_cnt0", 32'(sb.busy_cnt), 0);

    // same-cycle pair dependency, then store-data exemption
    issue1(5'd7);
    sb.id_valid_2 = 1;
    sb.id_rs2_2 = 5'd7;
    #1;
    chk("t2_stall_1", 32'(sb.ID_stall_1), 0);
    chk("t2_pair_dep", 32'(sb.ID_stall_2), 1);
    sb.id_is_s_type_2 = 1;
    #1 chk("t2_store_ok", 32'(sb.ID_stall_2), 0);
    tick();
    idle();
    sb.wb_en_1 = 1;
    sb.wb_rd_1 = 5'd7;
    tick();

    // x0 producer is never tracked
    issue1(5'd0);
    tick();
    idle();
    sb.id_valid_1 = 1;
    #1;
    chk("t3_x0_cnt", 32'(sb.busy_cnt), 0);
    chk("t3_x0_stall", 32'(sb.ID_stall_1), 0);
    tick();

    // reissue to x9 in the cycle x9 is released
    issue1(5'd9);
    tick();
    issue1(5'd9);
    sb.wb_en_2 = 1;
    sb.wb_rd_2 = 5'd9;
    #1 chk("t4_waw_bypass", 32'(sb.ID_stall_1), 0);
    tick();
    idle();
    sb.id_valid_1 = 1;
    sb.id_rs1_1 = 5'd9;
    #1;
    chk("t4_still_busy", 32'(sb.ID_stall_1), 1);
    chk("t4_cnt", 32'(sb.busy_cnt), 1);
    idle();
    sb.wb_en_1 = 1;
    sb.wb_rd_1 = 5'd9;
    tick();

    // fill every register, then flush
    for (int i = 1; i < NREG; i++) begin
      issue1(5'(i));
      tick();
    end
    idle();
    #1 chk("t5_full", 32'(sb.busy_cnt), 31);
    flush = 1'b1;
    sb.wb_en_1 = 1;
    sb.wb_rd_1 = 5'd3;
    tick();
    idle();
    sb.id_valid_1 = 1;
    sb.id_rs1_1 = 5'd3;
    #1;
    chk("t5_flush_cnt", 32'(sb.busy_cnt), 0);
    chk("t5_flush_idle", 32'(sb.sb_idle), 1);
    chk("t5_flush_stall", 32'(sb.ID_stall_1), 0);

    // spurious and duplicate releases
    idle();
    sb.wb_en_2 = 1;
    sb.wb_rd_2 = 5'd12;
    tick();
    idle();
    #1 chk("t6_no_underflow", 32'(sb.busy_cnt), 0);
    issue1(5'd3);
    tick();
    idle();
    sb.wb_en_2 = 1;
    sb.wb_rd_2 = 5'd12;
    tick();
    idle();
    #1 chk("t6_spurious", 32'(sb.busy_cnt), 1);
    sb.wb_en_1 = 1;
    sb.wb_en_2 = 1;
    sb.wb_rd_1 = 5'd3;
    sb.wb_rd_2 = 5'd3;
    tick();
    idle();
    #1 chk("t6_dup_release", 32'(sb.busy_cnt), 0);

    // dual accept, then in-order stall cascade
    issue1(5'd10);
    sb.id_valid_2 = 1;
    sb.id_long_2 = 1;
    sb.id_rd_2 = 5'd11;
    tick();
    idle();
    sb.id_valid_1 = 1;
    sb.id_rs1_1 = 5'd10;
    sb.id_valid_2 = 1;
    #1;
    chk("t7_dual_cnt", 32'(sb.busy_cnt), 2);
    chk("t7_in_order", 32'(sb.ID_stall_2), 1);
    tick();

    // synchronous reset mid-operation
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("t8_rst_cnt", 32'(sb.busy_cnt), 0);
    tick();
    tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Register scoreboard for the two-issue pipeline. It tracks which architectural registers are owned by in-flight long-latency producers (loads, multi-cycle ops). A producer is marked at issue and released at writeback. The block answers per-slot issue-stall queries for both decode slots. It is the producer-tracking counterpart of the decode-stage stall check: it records destinations as they leave ID and clears them as results return, so hazards spanning more than one stage are held correctly.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- CNTW, 6, width of the outstanding-producer counter.

Ports:
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous and active-high.
- flush  in  1  pipeline flush; clears all scoreboard state.
- id_valid_1, id_valid_2  in  1 each  decode slot holds a valid instruction.
- id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2  in  5 each  source registers per slot.
- id_is_s_type_1, id_is_s_type_2  in  1 each  store; rs2 is store data, forwarded later, and is not checked.
- id_rd_1, id_rd_2  in  5 each  destination register per slot.
- id_long_1, id_long_2  in  1 each  slot is a long-latency producer that writes rd.
- wb_en_1, wb_en_2  in  1 each  writeback port releases a register.
- wb_rd_1, wb_rd_2  in  5 each  released register.
- ID_stall_1  out  1  slot 1 must not issue this cycle.
- ID_stall_2  out  1  slot 2 must not issue this cycle.
- busy_cnt  out  CNTW  number of registers currently owned.
- sb_idle  out  1  busy_cnt == 0.

## Operation
- State: busy[NREG-1:0] and busy_cnt. busy[0] is never set.
- Effective busy: eff_busy[r] = busy[r] & ~(wb_en_1 & wb_rd_1==r) & ~(wb_en_2 & wb_rd_2==r). A same-cycle release bypasses into the stall check.
- Slot-k hazard, hz_k, is the OR of:
  - eff_busy[rs1_k];
  - eff_busy[rs2_k] when ~is_s_type_k;
  - eff_busy[rd_k] when long_k (WAW).
  - Register 0 never hazards.
- ID_stall_1 = id_valid_1 & hz_1.
- ID_stall_2 = id_valid_2 & (hz_2 | ID_stall_1 | pair_dep).
  - pair_dep = id_valid_1 & id_long_1 & id_rd_1≠0 & (id_rd_1==rs1_2 | (id_rd_1==rs2_2 & ~is_s_type_2) | (id_long_2 & id_rd_2==id_rd_1)).
  - Issue is strictly in order: slot 2 never issues past a stalled slot 1.
- Accept: acc_k = id_valid_k & ~ID_stall_k & id_long_k & id_rd_k≠0.
- Next state:
  - busy[r] set if accepted this cycle; else cleared if released this cycle; else held. Set wins over a same-cycle release of the same r.
  - busy_cnt += popcount of accepts − popcount of releases of registers that were busy[r]=1.
  - A release of a non-busy register is ignored and does not decrement.
  - Two releases of the same r in one cycle count once.
- flush (and rst): busy ← 0, busy_cnt ← 0. Same-cycle accepts and releases are discarded. flush has priority over all updates.

## Timing
- Reset values: busy=0, busy_cnt=0, sb_idle=1. ID_stall_* are 0 whenever valids are 0.
- ID_stall_* are combinational from the current inputs plus registered busy; no added latency.
- An accepted long issue at cycle t stalls dependents from t+1.
- A release at cycle t unblocks dependents in cycle t (bypass). busy drops at t+1.
- busy_cnt max is NREG−1 = 31, which fits CNTW=6; the counter never wraps.
- rst mid-operation behaves like flush, since rst is synchronous.

## Structure
- Shared package: NREG, register-index width (5), and CNTW.
- One natural sub-module, sb_hazard_check: a purely combinational per-slot hazard function (rs1, rs2, rd, is_s_type, long, eff_busy → hz). It is instantiated twice.
- Busy vector, counter, and the accept/release update logic live in load_scoreboard.

## Test plan
- Issue a long op to rd=5 in slot 1, then next cycle slot 1 reads rs1=5 → ID_stall_1=1 and busy_cnt=1. Release wb_rd_1=5 in a later cycle → ID_stall_1=0 that same cycle, and busy_cnt=0 the next cycle.
- Same-cycle pair: slot 1 is a long op with rd=7, slot 2 reads rs2=7 → ID_stall_1=0, ID_stall_2=1. Repeat with slot 2 as an S-type using rs2=7 → ID_stall_2=0.
- rd=0 long op accepted → busy_cnt stays 0. A later read of x0 → no stall.
- Release rd=9 while a new long op with rd=9 is accepted in the same cycle → busy[9]=1 next cycle, and busy_cnt is unchanged.
- Fill registers 1..31 over consecutive cycles → busy_cnt=31. Assert flush → busy_cnt=0 and sb_idle=1 next cycle, with no stalls.
- Spurious wb_en_2 with rd=12 while register 12 is not busy → busy_cnt unchanged, and it never underflows.
